// File: rtl/uart_tx_if.sv
// Parallel-side handshake for the UART transmitter: byte + start strobe in,
// serial line and frame status out.
interface uart_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  modport master (output tx_data, output tx_start,
                  input  tx_out,  input  tx_busy, input tx_done);
  modport slave  (input  tx_data, input  tx_start,
                  output tx_out,  output tx_busy, output tx_done);
endinterface

// File: rtl/uart_tx.sv
// 8N1 serial transmitter: start bit, 8 data bits LSB first, stop bit, each
// held BIT_PERIOD clocks. Line idles high and is driven straight from a flop.
module uart_tx #(
  parameter int BIT_PERIOD = 10
) (
  input  logic     clk,
  input  logic     rst,
  uart_tx_if.slave bus
);
  localparam int CW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(BIT_PERIOD - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_PERIOD - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [8:0]    shift_q, shift_d;
  logic          tx_out_q, tx_out_d;
  logic          tx_busy_q, tx_busy_d;
  logic          tx_done_q, tx_done_d;
  logic          period_end;

  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    tx_busy_d  = tx_busy_q;
    tx_done_d  = 1'b0;
    period_end = (clk_cnt_q == CNT_MAX);

    case (state_q)
      IDLE: begin
        if (bus.tx_start) begin
          state_d   = START;
          clk_cnt_d = '0;
          bit_idx_d = '0;
          shift_d   = {1'b1, bus.tx_data};
          tx_busy_d = 1'b1;
        end
      end
      START: begin
        if (period_end) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (period_end) begin
          clk_cnt_d = '0;
          shift_d   = {1'b1, shift_q[8:1]};
          if (bit_idx_q == 3'd7) state_d = STOP;
          else bit_idx_d = bit_idx_q + 1'b1;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        // Registered pulse: raise it one edge early so it lands on the last stop cycle.
        tx_done_d = (clk_cnt_q == CNT_LAST);
        if (period_end) begin
          clk_cnt_d = '0;
          state_d   = IDLE;
          tx_busy_d = 1'b0;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the state being entered, so it only moves at bit boundaries.
    case (state_d)
      START:   tx_out_d = 1'b0;
      DATA:    tx_out_d = shift_d[0];
      default: tx_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= 9'h1FF;
      tx_out_q  <= 1'b1;
      tx_busy_q <= 1'b0;
      tx_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_out_q  <= tx_out_d;
      tx_busy_q <= tx_busy_d;
      tx_done_q <= tx_done_d;
    end
  end

  assign bus.tx_out  = tx_out_q;
  assign bus.tx_busy = tx_busy_q;
  assign bus.tx_done = tx_done_q;
endmodule
